// File: rtl/uart_tx.sv
// uart_tx: asynchronous serial character transmitter.
// Takes bytes over a valid/ready handshake and sends each one LSB-first as
// start + 8 data + optional parity + stop bit(s) on a registered line output.
// tx_active is high for the whole frame and drives the RS-485 driver-enable.
//
// Ports:
//   clk       system clock
//   rst       asynchronous reset, active high
//   clk_div   clocks per bit (values below 2 act as 2), latched at accept
//   tx_data   byte to send, latched at accept
//   tx_valid  tx_data valid
//   tx_ready  byte can be accepted this cycle (idle, or last cycle of last stop bit)
//   tx        serial line output, idle high
//   tx_active frame in progress
module uart_tx #(
    parameter int DIV_WIDTH = 16,
    parameter int PARITY    = 1,   // 0 none, 1 even, 2 odd
    parameter int STOP_BITS = 1    // 1 or 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DIV_WIDTH-1:0] clk_div,
    input  logic [7:0]           tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_active
);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    // Index of the final stop bit (stop counter is 0 or 1).
    localparam logic LAST_STOP = (STOP_BITS == 2);

    state_t               state;
    logic [DIV_WIDTH-1:0] per_m1;   // latched bit period minus one
    logic [DIV_WIDTH-1:0] cnt;      // cycles left in current bit, counts down to 0
    logic [2:0]           bitcnt;
    logic                 stopcnt;
    logic [7:0]           shreg;
    logic                 par_bit;

    logic                 accept;
    logic [DIV_WIDTH-1:0] div_m1;
    logic                 data_par;

    assign accept   = tx_valid & tx_ready;
    // A period below 2 is clamped to 2 so that every bit has a distinct
    // "second to last" cycle in which tx_ready can be raised.
    assign div_m1   = (clk_div < DIV_WIDTH'(2)) ? DIV_WIDTH'(1) : clk_div - DIV_WIDTH'(1);
    assign data_par = (PARITY == 2) ? ~(^tx_data) : ^tx_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            tx        <= 1'b1;
            tx_active <= 1'b0;
            tx_ready  <= 1'b1;
            per_m1    <= '0;
            cnt       <= '0;
            bitcnt    <= '0;
            stopcnt   <= 1'b0;
            shreg     <= '0;
            par_bit   <= 1'b0;
        end else if (accept) begin
            // tx_ready is only high in IDLE or the final stop cycle, so an
            // accept always starts a fresh frame with no gap.
            state     <= START;
            per_m1    <= div_m1;
            cnt       <= div_m1;
            shreg     <= tx_data;
            par_bit   <= data_par;
            tx        <= 1'b0;
            tx_active <= 1'b1;
            tx_ready  <= 1'b0;
        end else begin
            case (state)
                IDLE: ;
                START: begin
                    if (cnt != '0) begin
                        cnt <= cnt - DIV_WIDTH'(1);
                    end else begin
                        state  <= DATA;
                        cnt    <= per_m1;
                        bitcnt <= '0;
                        tx     <= shreg[0];
                        shreg  <= shreg >> 1;
                    end
                end
                DATA: begin
                    if (cnt != '0) begin
                        cnt <= cnt - DIV_WIDTH'(1);
                    end else if (bitcnt == 3'd7) begin
                        cnt     <= per_m1;
                        stopcnt <= 1'b0;
                        if (PARITY != 0) begin
                            state <= PAR;
                            tx    <= par_bit;
                        end else begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end
                    end else begin
                        cnt    <= per_m1;
                        bitcnt <= bitcnt + 3'd1;
                        tx     <= shreg[0];
                        shreg  <= shreg >> 1;
                    end
                end
                PAR: begin
                    if (cnt != '0) begin
                        cnt <= cnt - DIV_WIDTH'(1);
                    end else begin
                        state   <= STOP;
                        cnt     <= per_m1;
                        stopcnt <= 1'b0;
                        tx      <= 1'b1;
                    end
                end
                STOP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - DIV_WIDTH'(1);
                        // Registered ready: raise it one cycle early so it is
                        // high exactly in the final cycle of the last stop bit.
                        if (cnt == DIV_WIDTH'(1) && stopcnt == LAST_STOP)
                            tx_ready <= 1'b1;
                    end else if (stopcnt != LAST_STOP) begin
                        stopcnt <= 1'b1;
                        cnt     <= per_m1;
                    end else begin
                        state     <= IDLE;
                        tx        <= 1'b1;
                        tx_active <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx. Three instances cover even parity
// with one stop bit, odd parity, and no parity with two stop bits. Inputs are
// driven on the falling edge and outputs are sampled on the falling edge.
module tb_uart_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] clk_div = 16'd4;
    logic [7:0]  tx_data = 8'h00;
    logic        tv_e = 1'b0, tv_o = 1'b0, tv_s = 1'b0;
    logic        rdy_e, tx_e, act_e;
    logic        rdy_o, tx_o, act_o;
    logic        rdy_s, tx_s, act_s;

    int checks = 0;
    int errors = 0;
    logic [21:0] seq;

    always #5 clk = ~clk;

    uart_tx #(.DIV_WIDTH(16), .PARITY(1), .STOP_BITS(1)) dut_e (
        .clk(clk), .rst(rst), .clk_div(clk_div), .tx_data(tx_data), .tx_valid(tv_e),
        .tx_ready(rdy_e), .tx(tx_e), .tx_active(act_e));

    uart_tx #(.DIV_WIDTH(16), .PARITY(2), .STOP_BITS(1)) dut_o (
        .clk(clk), .rst(rst), .clk_div(clk_div), .tx_data(tx_data), .tx_valid(tv_o),
        .tx_ready(rdy_o), .tx(tx_o), .tx_active(act_o));

    uart_tx #(.DIV_WIDTH(16), .PARITY(0), .STOP_BITS(2)) dut_s (
        .clk(clk), .rst(rst), .clk_div(clk_div), .tx_data(tx_data), .tx_valid(tv_s),
        .tx_ready(rdy_s), .tx(tx_s), .tx_active(act_s));

    task automatic test_reset();
        @(negedge clk);
        checks++; if ({tx_e, act_e, rdy_e} !== 3'b101) begin errors++;
            $display("FAIL reset_e got tx/act/rdy=%b exp 101", {tx_e, act_e, rdy_e}); end
        checks++; if ({tx_o, act_o, rdy_o} !== 3'b101) begin errors++;
            $display("FAIL reset_o got tx/act/rdy=%b exp 101", {tx_o, act_o, rdy_o}); end
        checks++; if ({tx_s, act_s, rdy_s} !== 3'b101) begin errors++;
            $display("FAIL reset_s got tx/act/rdy=%b exp 101", {tx_s, act_s, rdy_s}); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if ({tx_e, act_e, rdy_e} !== 3'b101) begin errors++;
            $display("FAIL idle_after_reset got tx/act/rdy=%b exp 101", {tx_e, act_e, rdy_e}); end
    endtask

    // 0x55 even parity: four ones -> parity 0. 11 bits x 4 clks.
    task automatic test_even_parity();
        clk_div = 16'd4; tx_data = 8'h55; tv_e = 1'b1;
        seq = {11'b0, 1'b1, 1'b0, 8'h55, 1'b0};
        for (int i = 0; i < 44; i++) begin
            @(negedge clk);
            if (i == 0) tv_e = 1'b0;
            checks++; if (tx_e !== seq[i/4]) begin errors++;
                $display("FAIL even_tx cyc %0d got %b exp %b", i, tx_e, seq[i/4]); end
            checks++; if (act_e !== 1'b1) begin errors++;
                $display("FAIL even_active cyc %0d got %b exp 1", i, act_e); end
            checks++; if (rdy_e !== (i == 43)) begin errors++;
                $display("FAIL even_ready cyc %0d got %b exp %b", i, rdy_e, (i == 43)); end
        end
        @(negedge clk);
        checks++; if ({tx_e, act_e, rdy_e} !== 3'b101) begin errors++;
            $display("FAIL even_idle got tx/act/rdy=%b exp 101", {tx_e, act_e, rdy_e}); end
    endtask

    // 0x00 odd parity: zero ones -> parity 1. 11 bits x 3 clks.
    task automatic test_odd_parity();
        clk_div = 16'd3; tx_data = 8'h00; tv_o = 1'b1;
        seq = {11'b0, 1'b1, 1'b1, 8'h00, 1'b0};
        for (int i = 0; i < 33; i++) begin
            @(negedge clk);
            if (i == 0) tv_o = 1'b0;
            checks++; if (tx_o !== seq[i/3]) begin errors++;
                $display("FAIL odd_tx cyc %0d got %b exp %b", i, tx_o, seq[i/3]); end
            checks++; if (act_o !== 1'b1) begin errors++;
                $display("FAIL odd_active cyc %0d got %b exp 1", i, act_o); end
            checks++; if (rdy_o !== (i == 32)) begin errors++;
                $display("FAIL odd_ready cyc %0d got %b exp %b", i, rdy_o, (i == 32)); end
        end
        @(negedge clk);
        checks++; if ({tx_o, act_o, rdy_o} !== 3'b101) begin errors++;
            $display("FAIL odd_idle got tx/act/rdy=%b exp 101", {tx_o, act_o, rdy_o}); end
    endtask

    // 0xA5 then 0x3C, both with four ones -> parity 0. 88 clks, no gap.
    task automatic test_back_to_back();
        clk_div = 16'd4; tx_data = 8'hA5; tv_e = 1'b1;
        seq = {1'b1, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0};
        for (int i = 0; i < 88; i++) begin
            @(negedge clk);
            if (i == 0)  tx_data = 8'h3C;
            if (i == 44) tv_e = 1'b0;
            checks++; if (tx_e !== seq[i/4]) begin errors++;
                $display("FAIL b2b_tx cyc %0d got %b exp %b", i, tx_e, seq[i/4]); end
            checks++; if (act_e !== 1'b1) begin errors++;
                $display("FAIL b2b_active cyc %0d got %b exp 1", i, act_e); end
            checks++; if (rdy_e !== (i == 43 || i == 87)) begin errors++;
                $display("FAIL b2b_ready cyc %0d got %b exp %b", i, rdy_e, (i == 43 || i == 87)); end
        end
        @(negedge clk);
        checks++; if ({tx_e, act_e, rdy_e} !== 3'b101) begin errors++;
            $display("FAIL b2b_idle got tx/act/rdy=%b exp 101", {tx_e, act_e, rdy_e}); end
    endtask

    task automatic test_clk_div();
        // clk_div=0 -> 2 clks/bit. 0x01: one 1 -> even parity 1.
        clk_div = 16'd0; tx_data = 8'h01; tv_e = 1'b1;
        seq = {11'b0, 1'b1, 1'b1, 8'h01, 1'b0};
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            if (i == 0) tv_e = 1'b0;
            checks++; if (tx_e !== seq[i/2]) begin errors++;
                $display("FAIL div0_tx cyc %0d got %b exp %b", i, tx_e, seq[i/2]); end
            checks++; if (rdy_e !== (i == 21)) begin errors++;
                $display("FAIL div0_ready cyc %0d got %b exp %b", i, rdy_e, (i == 21)); end
        end
        @(negedge clk);
        checks++; if (act_e !== 1'b0) begin errors++;
            $display("FAIL div0_end got act=%b exp 0", act_e); end
        // clk_div=1 -> 2 clks/bit. 0x80: one 1 -> even parity 1.
        clk_div = 16'd1; tx_data = 8'h80; tv_e = 1'b1;
        seq = {11'b0, 1'b1, 1'b1, 8'h80, 1'b0};
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            if (i == 0) tv_e = 1'b0;
            checks++; if (tx_e !== seq[i/2]) begin errors++;
                $display("FAIL div1_tx cyc %0d got %b exp %b", i, tx_e, seq[i/2]); end
            checks++; if (rdy_e !== (i == 21)) begin errors++;
                $display("FAIL div1_ready cyc %0d got %b exp %b", i, rdy_e, (i == 21)); end
        end
        @(negedge clk);
        checks++; if (act_e !== 1'b0) begin errors++;
            $display("FAIL div1_end got act=%b exp 0", act_e); end
        // clk_div 4 -> 8 mid-frame: frame stays at 4 clks/bit. 0x0F parity 0.
        clk_div = 16'd4; tx_data = 8'h0F; tv_e = 1'b1;
        seq = {11'b0, 1'b1, 1'b0, 8'h0F, 1'b0};
        for (int i = 0; i < 44; i++) begin
            @(negedge clk);
            if (i == 0) tv_e = 1'b0;
            if (i == 4) clk_div = 16'd8;
            checks++; if (tx_e !== seq[i/4]) begin errors++;
                $display("FAIL divchg_tx cyc %0d got %b exp %b", i, tx_e, seq[i/4]); end
            checks++; if (rdy_e !== (i == 43)) begin errors++;
                $display("FAIL divchg_ready cyc %0d got %b exp %b", i, rdy_e, (i == 43)); end
        end
        @(negedge clk);
        checks++; if ({tx_e, act_e, rdy_e} !== 3'b101) begin errors++;
            $display("FAIL divchg_idle got tx/act/rdy=%b exp 101", {tx_e, act_e, rdy_e}); end
    endtask

    task automatic test_reset_mid_frame();
        // 0xF0: bit 3 is 0; cycle index 17 lies inside data bit 3.
        clk_div = 16'd4; tx_data = 8'hF0; tv_e = 1'b1;
        seq = {11'b0, 1'b1, 1'b0, 8'hF0, 1'b0};
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            if (i == 0) tv_e = 1'b0;
            checks++; if (tx_e !== seq[i/4]) begin errors++;
                $display("FAIL prerst_tx cyc %0d got %b exp %b", i, tx_e, seq[i/4]); end
        end
        rst = 1'b1;
        #1;
        checks++; if ({tx_e, act_e, rdy_e} !== 3'b101) begin errors++;
            $display("FAIL async_rst got tx/act/rdy=%b exp 101", {tx_e, act_e, rdy_e}); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if ({tx_e, act_e, rdy_e} !== 3'b101) begin errors++;
            $display("FAIL postrst_idle got tx/act/rdy=%b exp 101", {tx_e, act_e, rdy_e}); end
        // 0x5A: four ones -> parity 0.
        tx_data = 8'h5A; tv_e = 1'b1;
        seq = {11'b0, 1'b1, 1'b0, 8'h5A, 1'b0};
        for (int i = 0; i < 44; i++) begin
            @(negedge clk);
            if (i == 0) tv_e = 1'b0;
            checks++; if (tx_e !== seq[i/4]) begin errors++;
                $display("FAIL postrst_tx cyc %0d got %b exp %b", i, tx_e, seq[i/4]); end
            checks++; if (act_e !== 1'b1) begin errors++;
                $display("FAIL postrst_active cyc %0d got %b exp 1", i, act_e); end
        end
        @(negedge clk);
        checks++; if ({tx_e, act_e, rdy_e} !== 3'b101) begin errors++;
            $display("FAIL postrst_end got tx/act/rdy=%b exp 101", {tx_e, act_e, rdy_e}); end
    endtask

    // No parity, two stop bits, 0xFF, 5 clks/bit -> 55 clks.
    task automatic test_two_stop();
        clk_div = 16'd5; tx_data = 8'hFF; tv_s = 1'b1;
        seq = {11'b0, 2'b11, 8'hFF, 1'b0};
        for (int i = 0; i < 55; i++) begin
            @(negedge clk);
            if (i == 0) tv_s = 1'b0;
            checks++; if (tx_s !== seq[i/5]) begin errors++;
                $display("FAIL stop2_tx cyc %0d got %b exp %b", i, tx_s, seq[i/5]); end
            checks++; if (act_s !== 1'b1) begin errors++;
                $display("FAIL stop2_active cyc %0d got %b exp 1", i, act_s); end
            checks++; if (rdy_s !== (i == 54)) begin errors++;
                $display("FAIL stop2_ready cyc %0d got %b exp %b", i, rdy_s, (i == 54)); end
        end
        @(negedge clk);
        checks++; if ({tx_s, act_s, rdy_s} !== 3'b101) begin errors++;
            $display("FAIL stop2_idle got tx/act/rdy=%b exp 101", {tx_s, act_s, rdy_s}); end
    endtask

    initial begin
        test_reset();
        test_even_parity();
        test_odd_parity();
        test_back_to_back();
        test_clk_div();
        test_reset_mid_frame();
        test_two_stop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
